// File: rtl/id_ex_stage_if.sv
// Bundle between the decode stage and the ID/EX register: decoded fields
// coming in from ID, registered copies going out to EX, and the hazard,
// halt and stall-count indications back to the front end and debug unit.
interface id_ex_stage_if #(
  parameter int NB_DATA      = 32,
  parameter int NB_OP        = 6,
  parameter int NB_FUNCT     = 6,
  parameter int NB_REG       = 5,
  parameter int N_REGDEST    = 2,
  parameter int NB_STALL_CNT = 16
);
  logic                    enable_i;
  logic                    flush_i;
  logic [NB_OP-1:0]        opcode_i;
  logic [NB_FUNCT-1:0]     funct_i;
  logic                    tipeI_i;
  logic [N_REGDEST-1:0]    regDest_signal_i;
  logic [5:0]              mem_signals_i;
  logic [2:0]              wb_signals_i;
  logic [NB_DATA-1:0]      dataA_i;
  logic [NB_DATA-1:0]      dataB_i;
  logic [NB_DATA-1:0]      immediate_i;
  logic [NB_DATA-1:0]      pc_i;
  logic [NB_REG-1:0]       rs_i;
  logic [NB_REG-1:0]       rt_i;
  logic [NB_REG-1:0]       rd_i;

  logic [NB_OP-1:0]        opcode_o;
  logic [NB_FUNCT-1:0]     funct_o;
  logic                    tipeI_o;
  logic [N_REGDEST-1:0]    regDest_signal_o;
  logic [5:0]              mem_signals_o;
  logic [2:0]              wb_signals_o;
  logic [NB_DATA-1:0]      dataA_o;
  logic [NB_DATA-1:0]      dataB_o;
  logic [NB_DATA-1:0]      immediate_o;
  logic [NB_DATA-1:0]      pc_o;
  logic [NB_REG-1:0]       rs_o;
  logic [NB_REG-1:0]       rt_o;
  logic [NB_REG-1:0]       rd_o;
  logic                    stall_o;
  logic                    halt_o;
  logic [NB_STALL_CNT-1:0] stall_cnt_o;

  // Decode side: drives the ID fields, observes the stage outputs
  modport master (
    output enable_i, flush_i, opcode_i, funct_i, tipeI_i, regDest_signal_i,
           mem_signals_i, wb_signals_i, dataA_i, dataB_i, immediate_i, pc_i,
           rs_i, rt_i, rd_i,
    input  opcode_o, funct_o, tipeI_o, regDest_signal_o, mem_signals_o,
           wb_signals_o, dataA_o, dataB_o, immediate_o, pc_o, rs_o, rt_o,
           rd_o, stall_o, halt_o, stall_cnt_o
  );

  // Pipeline register side: consumes the ID fields, produces the EX copies
  modport slave (
    input  enable_i, flush_i, opcode_i, funct_i, tipeI_i, regDest_signal_i,
           mem_signals_i, wb_signals_i, dataA_i, dataB_i, immediate_i, pc_i,
           rs_i, rt_i, rd_i,
    output opcode_o, funct_o, tipeI_o, regDest_signal_o, mem_signals_o,
           wb_signals_o, dataA_o, dataB_o, immediate_o, pc_o, rs_o, rt_o,
           rd_o, stall_o, halt_o, stall_cnt_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the MIPS core. Registers the decoded bundle,
// detects load-use hazards against the instruction in EX and inserts a
// bubble, latches HALT and counts inserted bubbles for the debug unit.
module id_ex_stage #(
  parameter int NB_DATA      = 32,
  parameter int NB_OP        = 6,
  parameter int NB_FUNCT     = 6,
  parameter int NB_REG       = 5,
  parameter int N_REGDEST    = 2,
  parameter int NB_STALL_CNT = 16
) (
  input logic          clock,
  input logic          reset,
  id_ex_stage_if.slave id_bus
);

  localparam logic [NB_OP-1:0] OP_NOP  = NB_OP'(6'b111110);
  localparam logic [NB_OP-1:0] OP_HALT = NB_OP'(6'b111111);

  logic [NB_REG-1:0] dest_ex;
  logic              dest_valid;
  logic              rt_is_src;
  logic              hazard;
  logic              advance;

  // Register the instruction in EX will write, if its regDest names one
  always_comb begin
    dest_ex    = '0;
    dest_valid = 1'b0;
    case (id_bus.regDest_signal_o)
      2'b00: begin
        dest_ex    = id_bus.rt_o;
        dest_valid = 1'b1;
      end
      2'b01: begin
        dest_ex    = id_bus.rd_o;
        dest_valid = 1'b1;
      end
      2'b10: begin
        dest_ex    = NB_REG'(31);
        dest_valid = 1'b1;
      end
      default: begin
        dest_ex    = '0;
        dest_valid = 1'b0;
      end
    endcase
  end

  // A load in EX whose result the ID instruction reads must wait one cycle;
  // rt only counts as a source for R-type and store instructions
  always_comb begin
    rt_is_src = !id_bus.tipeI_i || (id_bus.opcode_i[NB_OP-1 -: 3] == 3'b101);
    hazard    = id_bus.mem_signals_o[4] && id_bus.wb_signals_o[2] &&
                dest_valid && (dest_ex != '0) &&
                ((dest_ex == id_bus.rs_i) ||
                 (rt_is_src && (dest_ex == id_bus.rt_i)));
  end

  assign advance        = id_bus.enable_i && !id_bus.halt_o;
  assign id_bus.stall_o = hazard && advance;

  // Pipeline register: reset and bubbles load a NOP, otherwise take ID
  always_ff @(posedge clock) begin
    if (!reset || (advance && (id_bus.flush_i || hazard))) begin
      id_bus.opcode_o         <= OP_NOP;
      id_bus.funct_o          <= {NB_FUNCT{1'b0}};
      id_bus.tipeI_o          <= 1'b0;
      id_bus.regDest_signal_o <= {N_REGDEST{1'b0}};
      id_bus.mem_signals_o    <= 6'b0;
      id_bus.wb_signals_o     <= 3'b0;
      id_bus.dataA_o          <= {NB_DATA{1'b0}};
      id_bus.dataB_o          <= {NB_DATA{1'b0}};
      id_bus.immediate_o      <= {NB_DATA{1'b0}};
      id_bus.pc_o             <= {NB_DATA{1'b0}};
      id_bus.rs_o             <= {NB_REG{1'b0}};
      id_bus.rt_o             <= {NB_REG{1'b0}};
      id_bus.rd_o             <= {NB_REG{1'b0}};
    end else if (advance) begin
      id_bus.opcode_o         <= id_bus.opcode_i;
      id_bus.funct_o          <= id_bus.funct_i;
      id_bus.tipeI_o          <= id_bus.tipeI_i;
      id_bus.regDest_signal_o <= id_bus.regDest_signal_i;
      id_bus.mem_signals_o    <= id_bus.mem_signals_i;
      id_bus.wb_signals_o     <= id_bus.wb_signals_i;
      id_bus.dataA_o          <= id_bus.dataA_i;
      id_bus.dataB_o          <= id_bus.dataB_i;
      id_bus.immediate_o      <= id_bus.immediate_i;
      id_bus.pc_o             <= id_bus.pc_i;
      id_bus.rs_o             <= id_bus.rs_i;
      id_bus.rt_o             <= id_bus.rt_i;
      id_bus.rd_o             <= id_bus.rd_i;
    end
  end

  // HALT sticks from the edge that loads it until the next reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      id_bus.halt_o <= 1'b0;
    end else if (advance && !id_bus.flush_i && !hazard &&
                 (id_bus.opcode_i == OP_HALT)) begin
      id_bus.halt_o <= 1'b1;
    end
  end

  // Count hazard bubbles only (flushes are not stalls), saturating
  always_ff @(posedge clock) begin
    if (!reset) begin
      id_bus.stall_cnt_o <= {NB_STALL_CNT{1'b0}};
    end else if (advance && !id_bus.flush_i && hazard &&
                 (id_bus.stall_cnt_o != {NB_STALL_CNT{1'b1}})) begin
      id_bus.stall_cnt_o <= id_bus.stall_cnt_o + NB_STALL_CNT'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a reference model predicts each
// registered result when stimulus is driven, queues it, and the queue is
// drained and compared after the clock edge. The counter is narrowed to two
// bits so saturation is reachable.
module tb_id_ex_stage;

  localparam int NB_DATA      = 32;
  localparam int NB_OP        = 6;
  localparam int NB_FUNCT     = 6;
  localparam int NB_REG       = 5;
  localparam int N_REGDEST    = 2;
  localparam int NB_STALL_CNT = 2;

  localparam logic [5:0] OP_NOP  = 6'b111110;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] MEM_LW  = 6'b110100;
  localparam logic [5:0] MEM_SW  = 6'b001010;

  typedef struct {
    logic        enable;
    logic        flush;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        tipeI;
    logic [1:0]  regDest;
    logic [5:0]  mem;
    logic [2:0]  wb;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } stim_t;

  typedef struct {
    stim_t                   f;
    logic                    halt;
    logic [NB_STALL_CNT-1:0] cnt;
    bit                      dataCare;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  exp_t cur;
  bit   known = 1'b0;
  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  id_ex_stage_if #(
    .NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_FUNCT(NB_FUNCT), .NB_REG(NB_REG),
    .N_REGDEST(N_REGDEST), .NB_STALL_CNT(NB_STALL_CNT)
  ) bus ();

  id_ex_stage #(
    .NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_FUNCT(NB_FUNCT), .NB_REG(NB_REG),
    .N_REGDEST(N_REGDEST), .NB_STALL_CNT(NB_STALL_CNT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .id_bus(bus)
  );

  task automatic checkOutput(input string tag, input logic [255:0] obs,
                             input logic [255:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [255:0] ctrlPack(input logic [5:0] op, input logic t,
                                            input logic [1:0] rsel,
                                            input logic [5:0] m, input logic [2:0] w);
    return 256'({op, t, rsel, m, w});
  endfunction

  function automatic logic [255:0] dataPack(input logic [5:0] fn,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] imm, input logic [31:0] pc,
                                            input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [4:0] rd);
    return 256'({fn, a, b, imm, pc, rs, rt, rd});
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.enable  = 1'b1;
    s.flush   = 1'b0;
    s.opcode  = 6'($urandom);
    s.funct   = 6'($urandom);
    s.tipeI   = 1'($urandom);
    s.regDest = 2'($urandom);
    s.mem     = 6'($urandom);
    s.wb      = 3'($urandom);
    s.a       = $urandom;
    s.b       = $urandom;
    s.imm     = $urandom;
    s.pc      = $urandom;
    s.rs      = 5'($urandom);
    s.rt      = 5'($urandom);
    s.rd      = 5'($urandom);
    return s;
  endfunction

  function automatic stim_t instr(input logic [5:0] op, input logic t,
                                  input logic [1:0] rsel, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [5:0] m,
                                  input logic [2:0] w);
    stim_t s;
    s         = randStim();
    s.opcode  = op;
    s.tipeI   = t;
    s.regDest = rsel;
    s.rs      = rs;
    s.rt      = rt;
    s.mem     = m;
    s.wb      = w;
    return s;
  endfunction

  function automatic exp_t resetState();
    exp_t e;
    e.f          = '{default: '0};
    e.f.opcode   = OP_NOP;
    e.halt       = 1'b0;
    e.cnt        = '0;
    e.dataCare   = 1'b1;
    return e;
  endfunction

  function automatic bit modelHazard(input exp_t c, input stim_t s);
    logic [4:0] d;
    bit         v;
    bit         src;
    v = 1'b1;
    d = 5'd0;
    case (c.f.regDest)
      2'b00:   d = c.f.rt;
      2'b01:   d = c.f.rd;
      2'b10:   d = 5'd31;
      default: v = 1'b0;
    endcase
    src = !s.tipeI || (s.opcode[5:3] == 3'b101);
    return c.f.mem[4] && c.f.wb[2] && v && (d != 5'd0) &&
           ((d == s.rs) || (src && (d == s.rt)));
  endfunction

  task automatic applyStimulus(input stim_t s);
    exp_t nxt;
    exp_t want;
    bit   hz;
    bus.enable_i         = s.enable;
    bus.flush_i          = s.flush;
    bus.opcode_i         = s.opcode;
    bus.funct_i          = s.funct;
    bus.tipeI_i          = s.tipeI;
    bus.regDest_signal_i = s.regDest;
    bus.mem_signals_i    = s.mem;
    bus.wb_signals_i     = s.wb;
    bus.dataA_i          = s.a;
    bus.dataB_i          = s.b;
    bus.immediate_i      = s.imm;
    bus.pc_i             = s.pc;
    bus.rs_i             = s.rs;
    bus.rt_i             = s.rt;
    bus.rd_i             = s.rd;
    #1;
    hz = modelHazard(cur, s);
    if (known)
      checkOutput("stall", 256'(bus.stall_o), 256'(hz && s.enable && !cur.halt));
    nxt = cur;
    if (!reset) begin
      nxt = resetState();
    end else if (s.enable && !cur.halt) begin
      if (s.flush || hz) begin
        nxt.f.opcode  = OP_NOP;
        nxt.f.tipeI   = 1'b0;
        nxt.f.regDest = 2'b00;
        nxt.f.mem     = 6'b0;
        nxt.f.wb      = 3'b0;
        nxt.dataCare  = 1'b0;
        if (!s.flush && (nxt.cnt != '1))
          nxt.cnt = nxt.cnt + 1'b1;
      end else begin
        nxt.f        = s;
        nxt.dataCare = 1'b1;
        if (s.opcode == OP_HALT)
          nxt.halt = 1'b1;
      end
    end
    known = known || !reset;
    cur   = nxt;
    if (known)
      sbq.push_back(nxt);
    @(posedge clock);
    #1;
    if (sbq.size() > 0) begin
      want = sbq.pop_front();
      checkOutput("ctrl", ctrlPack(bus.opcode_o, bus.tipeI_o, bus.regDest_signal_o,
                                   bus.mem_signals_o, bus.wb_signals_o),
                  ctrlPack(want.f.opcode, want.f.tipeI, want.f.regDest,
                           want.f.mem, want.f.wb));
      if (want.dataCare)
        checkOutput("data", dataPack(bus.funct_o, bus.dataA_o, bus.dataB_o,
                                     bus.immediate_o, bus.pc_o, bus.rs_o,
                                     bus.rt_o, bus.rd_o),
                    dataPack(want.f.funct, want.f.a, want.f.b, want.f.imm,
                             want.f.pc, want.f.rs, want.f.rt, want.f.rd));
      checkOutput("halt", 256'(bus.halt_o), 256'(want.halt));
      checkOutput("stall_cnt", 256'(bus.stall_cnt_o), 256'(want.cnt));
    end
  endtask

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence: reset, load-use, false hazards, flush, saturation,
  // enable hold, HALT and reset during a stall
  initial begin
    stim_t s;
    stim_t consumers[3];

    for (int i = 0; i < 2; i++) begin
      s        = randStim();
      s.enable = 1'($urandom);
      s.flush  = 1'($urandom);
      applyStimulus(s);
    end
    reset = 1'b1;

    applyStimulus(instr(OP_LW, 1'b1, 2'b00, 5'd1, 5'd5, MEM_LW, 3'b100));
    applyStimulus(instr(OP_R, 1'b0, 2'b01, 5'd5, 5'd6, 6'b0, 3'b100));
    applyStimulus(instr(OP_R, 1'b0, 2'b01, 5'd5, 5'd6, 6'b0, 3'b100));

    applyStimulus(instr(OP_LW, 1'b1, 2'b00, 5'd2, 5'd0, MEM_LW, 3'b100));
    applyStimulus(instr(OP_R, 1'b0, 2'b01, 5'd0, 5'd0, 6'b0, 3'b100));
    applyStimulus(instr(OP_LW, 1'b1, 2'b00, 5'd2, 5'd7, MEM_LW, 3'b100));
    applyStimulus(instr(OP_ADDI, 1'b1, 2'b00, 5'd3, 5'd7, 6'b0, 3'b100));

    applyStimulus(instr(OP_LW, 1'b1, 2'b00, 5'd1, 5'd5, MEM_LW, 3'b100));
    s       = instr(OP_R, 1'b0, 2'b01, 5'd5, 5'd6, 6'b0, 3'b100);
    s.flush = 1'b1;
    applyStimulus(s);

    consumers[0] = instr(OP_R,  1'b0, 2'b01, 5'd9, 5'd4,  6'b0,   3'b100);
    consumers[1] = instr(OP_LW, 1'b1, 2'b00, 5'd9, 5'd10, MEM_LW, 3'b100);
    consumers[2] = instr(OP_SW, 1'b1, 2'b00, 5'd2, 5'd9,  MEM_SW, 3'b000);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(instr(OP_LW, 1'b1, 2'b00, 5'd1, 5'd9, MEM_LW, 3'b100));
      applyStimulus(consumers[i % 3]);
      applyStimulus(consumers[i % 3]);
    end

    applyStimulus(instr(OP_LW, 1'b1, 2'b00, 5'd1, 5'd5, MEM_LW, 3'b100));
    for (int i = 0; i < 5; i++) begin
      s        = randStim();
      s.enable = 1'b0;
      s.flush  = 1'($urandom);
      s.rs     = 5'd5;
      applyStimulus(s);
    end

    applyStimulus(instr(OP_HALT, 1'b1, 2'b01, 5'd1, 5'd2, 6'b0, 3'b000));
    for (int i = 0; i < 10; i++) begin
      s        = randStim();
      s.enable = 1'($urandom);
      s.flush  = 1'($urandom);
      applyStimulus(s);
    end

    reset = 1'b0;
    applyStimulus(randStim());
    reset = 1'b1;
    applyStimulus(instr(OP_LW, 1'b1, 2'b00, 5'd1, 5'd5, MEM_LW, 3'b100));
    reset = 1'b0;
    applyStimulus(instr(OP_R, 1'b0, 2'b01, 5'd5, 5'd6, 6'b0, 3'b100));
    reset = 1'b1;
    applyStimulus(instr(OP_R, 1'b0, 2'b01, 5'd5, 5'd6, 6'b0, 3'b100));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the MIPS core. Registers the decoded control bundle, operands and register indices produced by the decode stage, including the control unit. Detects load-use hazards against the instruction currently in EX and inserts bubbles. Latches HALT, and keeps a saturating stall counter for the debug unit.

## Interface

Parameters:
- NB_DATA, 32, operand, immediate and PC width
- NB_OP, 6, opcode width
- NB_FUNCT, 6, funct width
- NB_REG, 5, register index width
- N_REGDEST, 2, regDest selector width
- NB_STALL_CNT, 16, stall counter width

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low; all state initialised when sampled 0 at a rising edge
- enable_i  in  1  debug run/step enable; 0 holds all registers
- flush_i  in  1  taken branch/jump; discard the ID instruction
- opcode_i  in  NB_OP  opcode from ID
- funct_i  in  NB_FUNCT  funct from ID
- tipeI_i  in  1  I-type flag from control unit
- regDest_signal_i  in  N_REGDEST  00 rt, 01 rd, 10 reg 31
- mem_signals_i  in  6  [5] sign, [4] mem_read, [3] mem_write, [2:0] word/half/byte
- wb_signals_i  in  3  [2] regWrite, [1:0] mem_to_reg
- dataA_i, dataB_i, immediate_i, pc_i  in  NB_DATA  operands, sign-extended immediate, PC+4
- rs_i, rt_i, rd_i  in  NB_REG  register indices
- opcode_o … rd_o  out  same widths  registered copies of every *_i data/control input above
- stall_o  out  1  combinational; hold PC and IF/ID this cycle
- halt_o  out  1  registered, sticky HALT indication
- stall_cnt_o  out  NB_STALL_CNT  bubbles inserted by hazards, saturating

## Operation

- EX destination (dest_ex): rt_o if regDest_signal_o=00, rd_o if 01, 31 if 10, else none.
- Hazard (combinational) requires all three:
  - mem_signals_o[4]=1 and wb_signals_o[2]=1.
  - dest_ex≠0.
  - dest_ex equals rs_i, or equals rt_i while rt is a source. rt is a source when tipeI_i=0 or opcode_i[5:3]=3'b101 (stores).
- stall_o = hazard & enable_i & ~halt_o. flush_i does not gate stall_o.
- Bubble means all control outputs zero and opcode_o=6'b111110 (NOP); data outputs may take any value.
- Per rising edge, priority order:
  1. reset=0: initialise. Every output is 0, except opcode_o=6'b111110. halt_o=0, stall_cnt_o=0.
  2. enable_i=0: hold everything.
  3. halt_o=1: hold everything, including stall_cnt_o.
  4. flush_i=1: load a bubble. The counter is not incremented.
  5. hazard=1: load a bubble and increment stall_cnt_o, saturating at all-ones.
  6. Otherwise load all inputs.
- halt_o is set at the edge that loads opcode_i=6'b111111 under case 6. It stays set until reset. The HALT instruction itself remains visible on opcode_o.
- Flush and hazard in the same cycle: bubble per case 4, no count, stall_o still 1.

## Timing

- Latency is 1 cycle: the inputs sampled at edge N appear on the outputs after edge N.
- A load-use hazard costs exactly one bubble. After the bubble, the EX stage no longer holds the load, so stall_o drops and the held ID instruction loads on the next edge.
- Back-to-back loads each feeding the next also cost one bubble each.
- stall_o is valid in the same cycle as the inputs, with no registered delay. It is 0 while reset is asserted, because the outputs are NOP.
- Reset mid-stall: outputs return to reset values at that edge. stall_o is 0 in the following cycle.

## Test plan

- Reset: drive reset=0 for 2 cycles with random inputs. Then opcode_o=111110, wb_signals_o=000, mem_signals_o=000000, halt_o=0, stall_cnt_o=0.
- Load-use:
  - EX holds LW with rt_o=5, regDest 00, mem_signals 110100, wb 100.
  - ID holds R-type with rs_i=5.
  - stall_o=1. The next edge loads a bubble (opcode_o=111110) and stall_cnt_o=1. The following edge loads the R-type.
- No false hazard:
  - EX holds LW to rt_o=0; ID reads rs_i=0. Then stall_o=0.
  - EX holds LW to rt_o=7; ID holds ADDI (tipeI_i=1) with rt_i=7 and rs_i=3. Then stall_o=0.
- Flush with hazard: the load-use condition and flush_i=1 occur in the same cycle. Then stall_o=1, a bubble loads, and stall_cnt_o is unchanged.
- HALT: load opcode_i=111111 with enable_i=1. halt_o=1 from the next cycle. Ten further edges with changing inputs leave all outputs unchanged.
- Enable and saturation:
  - With enable_i=0 for 5 cycles, outputs are frozen and stall_o=0.
  - With NB_STALL_CNT=2, four hazards leave stall_cnt_o=3.
